// File: rtl/reg_file_2r1w_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file.
// The optional hardwired-zero entry 0 is enabled by defining REGFILE_ZERO_REG_EN.
`ifndef MEM_W
`define MEM_W 16
`endif
`ifndef REG_DEPTH
`define REG_DEPTH 16
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 4
`endif

package reg_file_2r1w_pkg;

    localparam int DEF_DATA_W   = `MEM_W;
    localparam int DEF_DEPTH    = `REG_DEPTH;
    localparam int DEF_ADDR_W   = `REG_ADDR_W;
    localparam int NUM_RD_PORTS = 2;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } rd_port_e;

    function automatic logic in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Decode-to-execute bus of the register file: clear, one write port, two read ports.
interface reg_file_2r1w_if
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;

    modport master (
        output clr, wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );
endinterface

// File: rtl/reg_file_2r1w_rd_port.sv
// One registered read port: entry select, write-first bypass, range check, valid strobe.
// With REGFILE_ZERO_REG_EN defined, address 0 always reads as zero.
module reg_file_rd_port
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DEPTH-1:0][DATA_W-1:0] mem,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid
);

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] sel;
    logic              hit;
    logic              byp;

    // Address decode doubles as the range check: no match means out of range.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                sel = mem[i];
                hit = 1'b1;
            end
        end
        byp = wr_en && hit && (wr_addr == rd_addr);
        if (byp) sel = wr_data;
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr == '0) sel = '0;
`endif
        // A clear wipes the array at this edge, so same-cycle reads see zero.
        if (clr) sel = '0;

        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        if (rd_en) rd_data_d = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file: storage array, write decode and bulk clear.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_2r1w_if.slave bus
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic                         wr_ok;

    logic [NUM_RD_PORTS-1:0]             rd_en;
    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]             rd_valid;

    always_comb begin
        wr_ok = bus.wr_en && in_range(32'(bus.wr_addr), DEPTH);
`ifdef REGFILE_ZERO_REG_EN
        if (bus.wr_addr == '0) wr_ok = 1'b0;
`endif
        mem_d = mem_q;
        if (bus.clr) begin
            mem_d = '0;
        end else if (wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.wr_addr == ADDR_W'(i)) mem_d[i] = bus.wr_data;
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        mem_d[0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign rd_en[PORT_A]   = bus.rd_en_a;
    assign rd_addr[PORT_A] = bus.rd_addr_a;
    assign rd_en[PORT_B]   = bus.rd_en_b;
    assign rd_addr[PORT_B] = bus.rd_addr_b;

    assign bus.rd_data_a  = rd_data[PORT_A];
    assign bus.rd_valid_a = rd_valid[PORT_A];
    assign bus.rd_data_b  = rd_data[PORT_B];
    assign bus.rd_valid_b = rd_valid[PORT_B];

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .clr      (bus.clr),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .mem      (mem_q),
            .rd_en    (rd_en[p]),
            .rd_addr  (rd_addr[p]),
            .rd_data  (rd_data[p]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule
